// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default widths for the mac_pipe multiply-add unit.
//   MAC_DATA_W / MAC_GUARD_W : default operand width and accumulator headroom.
//   mac_mode_e               : per-beat operation (single multiply-add or accumulate).
//   mac_s1_t                 : stage-1 payload (product, addend, mode, clear).
package mac_pkg;

    localparam int unsigned MAC_DATA_W  = 8;
    localparam int unsigned MAC_GUARD_W = 4;
    localparam int unsigned MAC_PROD_W  = 2 * MAC_DATA_W;
    localparam int unsigned MAC_ACC_W   = 2 * MAC_DATA_W + MAC_GUARD_W;

    typedef enum logic {
        MAC_SINGLE = 1'b0,
        MAC_ACCUM  = 1'b1
    } mac_mode_e;

    typedef struct packed {
        logic [MAC_PROD_W-1:0] prod;
        logic [MAC_DATA_W-1:0] c;
        mac_mode_e             mode;
        logic                  clear;
    } mac_s1_t;

endpackage

// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand/result handshake bundle for mac_pipe.
//   Input side : in_valid_i, in_ready_o, mode_i, clear_i, a_i, b_i, c_i
//   Output side: out_valid_o, out_ready_i, d_o, ovf_o
//   modport slave  : the mac_pipe unit
//   modport master : the producer/consumer driving the unit
// Signal names keep the unit's port names so existing hookups map one-to-one.
interface mac_pipe_if #(
    parameter int unsigned DATA_W  = mac_pkg::MAC_DATA_W,
    parameter int unsigned GUARD_W = mac_pkg::MAC_GUARD_W
) ();

    localparam int unsigned ACC_W = 2 * DATA_W + GUARD_W;

    logic              in_valid_i;
    logic              in_ready_o;
    logic              mode_i;
    logic              clear_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic [DATA_W-1:0] c_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ACC_W-1:0]  d_o;
    logic              ovf_o;

    modport slave (
        input  in_valid_i, mode_i, clear_i, a_i, b_i, c_i, out_ready_i,
        output in_ready_o, out_valid_o, d_o, ovf_o
    );

    modport master (
        output in_valid_i, mode_i, clear_i, a_i, b_i, c_i, out_ready_i,
        input  in_ready_o, out_valid_o, d_o, ovf_o
    );

endinterface

// File: rtl/mac_sat_add.sv
// mac_sat_add: W-bit three-input unsigned adder for the mac_pipe output stage.
//   a, b, c : addends
//   sat_en  : allow clamping for this operation
//   sum     : result (wrapped, or clamped to all-ones when saturating)
//   ovf     : result was clamped
// Build option MAC_PIPE_SAT_EN: when defined, sums exceeding 2^W-1 clamp if
// sat_en is set; when undefined the sum wraps and ovf is constant 0.
module mac_sat_add #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         sat_en,
    output logic [W-1:0] sum,
    output logic         ovf
);

`ifdef MAC_PIPE_SAT_EN
    // Two extra bits hold the carry-out of a three-operand sum.
    logic [W+1:0] full;
    logic         carry;

    assign full  = {2'b00, a} + {2'b00, b} + {2'b00, c};
    assign carry = |full[W+1:W];

    always_comb begin
        sum = full[W-1:0];
        ovf = 1'b0;
        if (sat_en && carry) begin
            sum = '1;
            ovf = 1'b1;
        end
    end
`else
    logic unused_sat_en;

    assign sum           = a + b + c;
    assign ovf           = 1'b0;
    assign unused_sat_en = sat_en;
`endif

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-add / accumulate, d = a*b + c.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset; drops all in-flight beats
//   bus    : mac_pipe_if.slave
//            in_valid_i/in_ready_o  beat handshake (mode_i, clear_i, a_i, b_i, c_i)
//            out_valid_o/out_ready_i result handshake (d_o, ovf_o)
// Stage 1 registers the product and beat controls; stage 2 (output register)
// adds base + prod + c, where base is the running accumulator for mode-1
// beats without clear. Stage-1 payload widths follow mac_pkg.
// Build option MAC_PIPE_SAT_EN: mode-1 results clamp to 2^ACC_W-1 and set a
// sticky ovf_o, cleared by a clear beat reaching stage 2; otherwise results
// wrap and ovf_o is 0.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W  = MAC_DATA_W,
    parameter int unsigned GUARD_W = MAC_GUARD_W
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mac_pipe_if.slave bus
);

    localparam int unsigned ACC_W  = 2 * DATA_W + GUARD_W;
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic             adv1;
    logic             adv2;

    logic             s1_v;
    mac_s1_t          s1_d;
    mac_s1_t          s1_q;

    logic             out_valid_q;
    logic [ACC_W-1:0] d_q;
    logic [ACC_W-1:0] acc_q;

    logic             s1_accum;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    // Stage 2 moves when its slot is empty or being drained; stage 1 moves
    // when it is empty or stage 2 takes its beat.
    assign adv2 = !out_valid_q || bus.out_ready_i;
    assign adv1 = !s1_v || adv2;

    assign bus.in_ready_o = adv1;

    always_comb begin
        s1_d       = '0;
        s1_d.prod  = {{DATA_W{1'b0}}, bus.a_i} * {{DATA_W{1'b0}}, bus.b_i};
        s1_d.c     = bus.c_i;
        s1_d.mode  = mac_mode_e'(bus.mode_i);
        s1_d.clear = bus.clear_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (adv1) begin
            s1_v <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_q <= s1_d;
            end
        end
    end

    assign s1_accum = (s1_q.mode == MAC_ACCUM);
    assign base     = (s1_accum && !s1_q.clear) ? acc_q : '0;

    mac_sat_add #(
        .W (ACC_W)
    ) u_add (
        .a      (base),
        .b      (ACC_W'(s1_q.prod)),
        .c      (ACC_W'(s1_q.c)),
        .sat_en (s1_accum),
        .sum    (sum),
        .ovf    (sum_ovf)
    );

    // Accumulator and output only change when a beat enters stage 2, so both
    // hold steady for as long as the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            acc_q       <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_v;
            if (s1_v) begin
                d_q <= sum;
                if (s1_accum) begin
                    acc_q <= sum;
                end else if (s1_q.clear) begin
                    acc_q <= '0;
                end
            end
        end
    end

`ifdef MAC_PIPE_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (adv2 && s1_v) begin
            ovf_q <= (ovf_q && !s1_q.clear) || sum_ovf;
        end
    end

    assign bus.ovf_o = ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf = sum_ovf;
    assign bus.ovf_o  = 1'b0;
`endif

    assign bus.out_valid_o = out_valid_q;
    assign bus.d_o         = d_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: self-checking bench for mac_pipe. Directed scenarios plus a
// randomized stream are scored against an arithmetic reference model that
// predicts each accepted beat's result at accept time (results emerge in order).
// Honours MAC_PIPE_SAT_EN the same way as the design.
module tb_mac_pipe;

    localparam int unsigned ACC_W   = 20;
    localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mac_pipe_if bus ();

    mac_pipe #(
        .DATA_W  (8),
        .GUARD_W (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        longint d;
        bit     ovf;
    } exp_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    exp_t   exp_q[$];
    longint seen_d[$];
    bit     seen_ovf[$];

    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    logic             smp_in_ready;
    logic             smp_out_valid;
    logic             smp_ovf;
    logic [ACC_W-1:0] smp_d;
    bit               took;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: result = base + a*b + c, base = running sum for accumulate
    // beats without clear; clamp (sat build) or wrap mod 2^ACC_W.
    task automatic model_push(input bit m, input bit clr,
                              input int unsigned a, input int unsigned b, input int unsigned c);
        longint r;
        bit     clamp;
        clamp = 1'b0;
        r = ((m && !clr) ? m_acc : 0) + longint'(a) * longint'(b) + longint'(c);
`ifdef MAC_PIPE_SAT_EN
        if (m && r > ACC_MAX) begin
            r     = ACC_MAX;
            clamp = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
        if (clamp) m_ovf = 1'b1;
`else
        r = r % (ACC_MAX + 1);
`endif
        if (m) m_acc = r;
        else if (clr) m_acc = 0;
        exp_q.push_back('{d: r, ovf: m_ovf});
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, score any
    // transfer that the following rising edge will perform.
    task automatic step(input bit v, input bit m, input bit clr,
                        input int unsigned a, input int unsigned b, input int unsigned c,
                        input bit ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.mode_i      = m;
        bus.clear_i     = clr;
        bus.a_i         = 8'(a);
        bus.b_i         = 8'(b);
        bus.c_i         = 8'(c);
        bus.out_ready_i = ordy;
        #1;
        smp_in_ready  = bus.in_ready_o;
        smp_out_valid = bus.out_valid_o;
        smp_d         = bus.d_o;
        smp_ovf       = bus.ovf_o;
        took          = v && smp_in_ready;
        if (smp_out_valid && ordy) begin
            check("out_has_expect", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("d", 64'(smp_d), e.d);
                check("ovf", 64'(smp_ovf), 64'(e.ovf));
                seen_d.push_back(longint'(smp_d));
                seen_ovf.push_back(smp_ovf);
            end
        end
        if (took) model_push(m, clr, a, b, c);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic clear_log();
        seen_d.delete();
        seen_ovf.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned k;
        logic [ACC_W-1:0] held_d;
        longint sat16;
        bit     sat_ovf;
`ifdef MAC_PIPE_SAT_EN
        sat16   = 1048575;
        sat_ovf = 1'b1;
`else
        sat16   = 61184;
        sat_ovf = 1'b0;
`endif
        bus.in_valid_i  = 1'b0;
        bus.mode_i      = 1'b0;
        bus.clear_i     = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.c_i         = '0;
        bus.out_ready_i = 1'b1;

        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid_o), 0);
        check("rst_d", 64'(bus.d_o), 0);
        check("rst_ovf", 64'(bus.ovf_o), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready_o), 1);

        // Mode 0 back-to-back streaming, latency 2
        clear_log();
        step(1'b1, 1'b0, 1'b0, 1, 2, 3, 1'b1);
        check("lat_s0", 64'(smp_out_valid), 0);
        step(1'b1, 1'b0, 1'b0, 4, 5, 6, 1'b1);
        check("lat_s1", 64'(smp_out_valid), 0);
        step(1'b1, 1'b0, 1'b0, 7, 8, 9, 1'b1);
        check("lat_s2", 64'(smp_out_valid), 1);
        idle();
        check("stream_b2", 64'(smp_d), 26);
        idle();
        check("stream_b3", 64'(smp_d), 65);
        drain();
        check("stream_n", 64'(seen_d.size()), 3);
        check("stream_0", 64'(seen_d[0]), 5);
        check("stream_1", 64'(seen_d[1]), 26);
        check("stream_2", 64'(seen_d[2]), 65);

        // Accumulate, then a single beat that must not disturb the sum
        clear_log();
        step(1'b1, 1'b1, 1'b1, 2, 3, 1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 2, 3, 1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1, 1, 1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
        check("acc_n", 64'(seen_d.size()), 5);
        check("acc_0", 64'(seen_d[0]), 7);
        check("acc_1", 64'(seen_d[1]), 14);
        check("acc_2", 64'(seen_d[2]), 14);
        check("acc_3", 64'(seen_d[3]), 2);
        check("acc_4", 64'(seen_d[4]), 14);

        // Backpressure: consumer stalls for 4 cycles
        clear_log();
        k      = 0;
        held_d = '0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            step(1'b1, 1'b0, 1'b0, k + 1, k + 1, k + 1, (t >= 4));
            if (t == 2) begin
                check("bp_two_accepts", 64'(k), 2);
                check("bp_ready_low", 64'(smp_in_ready), 0);
                held_d = smp_d;
            end
            if (t == 3) begin
                check("bp_ready_low2", 64'(smp_in_ready), 0);
                check("bp_d_stable", 64'(smp_d), 64'(held_d));
                check("bp_d_value", 64'(smp_d), 2);
                check("bp_valid_held", 64'(smp_out_valid), 1);
            end
            if (took) k++;
        end
        check("bp_accepts", 64'(k), 4);
        drain();
        check("bp_n", 64'(seen_d.size()), 4);
        check("bp_0", 64'(seen_d[0]), 2);
        check("bp_1", 64'(seen_d[1]), 6);
        check("bp_2", 64'(seen_d[2]), 12);
        check("bp_3", 64'(seen_d[3]), 20);

        // Saturation / wrap boundary: 17 x (255*255+255)
        clear_log();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, (i == 0), 255, 255, 255, 1'b1);
        drain();
        check("sat_n", 64'(seen_d.size()), 17);
        check("sat_16th_d", 64'(seen_d[15]), 1044480);
        check("sat_16th_ovf", 64'(seen_ovf[15]), 0);
        check("sat_17th_d", 64'(seen_d[16]), 64'(sat16));
        check("sat_17th_ovf", 64'(seen_ovf[16]), 64'(sat_ovf));
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
        drain();
        check("sat_hold_d", 64'(seen_d[17]), 64'(sat16));
        check("sat_hold_ovf", 64'(seen_ovf[17]), 64'(sat_ovf));
        step(1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1);
        drain();
        check("sat_clr_d", 64'(seen_d[18]), 0);
        check("sat_clr_ovf", 64'(seen_ovf[18]), 0);

        // Randomized traffic with random consumer stalls
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) != 0));
        end
        drain();

        // Asynchronous reset with two beats in flight
        step(1'b1, 1'b1, 1'b1, 9, 9, 9, 1'b1);
        step(1'b1, 1'b1, 1'b0, 9, 9, 9, 1'b1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        check("pre_rst_valid", 64'(bus.out_valid_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid_o), 0);
        check("arst_d", 64'(bus.d_o), 0);
        check("arst_ovf", 64'(bus.ovf_o), 0);
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        step(1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b1);
        drain();
        check("arst_n", 64'(seen_d.size()), 1);
        check("arst_first", 64'(seen_d[0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
